// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one fas cell stepped LSB-first over WIDTH
// cycles with a registered carry, reporting result/cout/ovf with a done pulse.

module fas (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  input  logic s_op_i,
  output logic s_o,
  output logic cout_o
);
  logic b_eff_s;

  // Subtract inverts b here; the +1 comes from the caller seeding cin.
  assign b_eff_s = b_i ^ s_op_i;
  assign s_o     = a_i ^ b_eff_s ^ cin_i;
  assign cout_o  = (a_i & b_eff_s) | (cin_i & (a_i ^ b_eff_s));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fas_s_s;
  logic             fas_cout_s;

  fas u_fas (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_op_i (op_q),
    .s_o    (fas_s_s),
    .cout_o (fas_cout_s)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          op_d     = op;
          carry_d  = op;
          cnt_d    = '0;
          res_sh_d = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_sh_d = {fas_s_s, res_sh_q[WIDTH-1:1]};
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        carry_d  = fas_cout_s;
        // carry_q is the carry into the MSB while the last bit is processed
        if (cnt_q == LAST_BIT) begin
          result_d = {fas_s_s, res_sh_q[WIDTH-1:1]};
          cout_d   = fas_cout_s;
          ovf_d    = carry_q ^ fas_cout_s;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (WIDTH = 8) with hand-computed expectations.

module tb_serial_addsub_ctrl;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int           n_assert;
  int           n_fail;
  logic [W-1:0] last_res;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 0 (DUT idle); returns in cycle W+2 with the DUT idle again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                        input logic [W-1:0] er, input logic ec, input logic eo,
                        input int e1, input int e2, input bit hold, input string tag);
    a_in  = a;
    b_in  = b;
    op    = o;
    start = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      if (hold) start = 1'b1;
      else      start = (k == e1) || (k == e2);
      if ((k == e1) || (k == e2)) begin
        a_in = ~a;
        b_in = 8'h11;
        op   = ~o;
      end
      check($sformatf("%s_busy_c%0d", tag, k), 32'(busy), 32'(k <= W));
      check($sformatf("%s_done_c%0d", tag, k), 32'(done), 32'(k == W + 1));
      if (k <= W) check($sformatf("%s_hold_c%0d", tag, k), 32'(result), 32'(last_res));
    end
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    last_res = er;
    @(posedge clk); #1;
    start = hold;
    check({tag, "_done_after"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_result_after"}, 32'(result), 32'(er));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    last_res = 8'h00;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    a_in     = 8'h00;
    b_in     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, -1, -1, 1'b0, "add_5a_33");
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, -1, -1, 1'b0, "sub_10_20");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1, -1, 1'b0, "add_ff_01");
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, -1, -1, 1'b0, "add_00_00");

    // start pulses in cycles 3 and 9 must be ignored; the follow-on op starts in cycle 10
    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 3, 9, 1'b0, "ign_start");
    run_op(8'h64, 8'h0A, 1'b1, 8'h5A, 1'b1, 1'b0, -1, -1, 1'b0, "sub_64_0a");
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, -1, -1, 1'b0, "sub_80_01");

    // Asynchronous reset in the middle of cycle 4 of an operation
    a_in  = 8'h55;
    b_in  = 8'h22;
    op    = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = 8'h00;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_done_c%0d", k), 32'(done), 32'd0);
      check($sformatf("post_rst_busy_c%0d", k), 32'(busy), 32'd0);
    end
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, -1, -1, 1'b0, "add_01_02");

    // start held high: back-to-back acceptance every W+2 cycles
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1, -1, 1'b1, "hold_op1");
    run_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, -1, -1, 1'b1, "hold_op2");
    run_op(8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0, -1, -1, 1'b1, "hold_op3");
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    repeat (W + 2) @(posedge clk);
    #1;
    check("hold_last_result", 32'(result), 32'h00000080);
    check("hold_final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
